// File: rtl/port_arbiter_if.sv
// rtl/port_arbiter_if.sv - requester-side and downstream handshake bundle for port_arbiter
interface port_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 11,
    parameter int SW = $clog2(N)
);
    logic [N-1:0]          req_write;
    logic [N-1:0][W-1:0]   req_data;
    logic [N-1:0]          req_wready;
    logic [N-1:0]          en_mask;
    logic                  out_write;
    logic [W-1:0]          out_data;
    logic [SW-1:0]         out_src;
    logic                  out_wready;
    logic                  busy;

    // Sources and the downstream consumer, as seen from outside the arbiter
    modport master (
        output req_write, req_data, en_mask, out_wready,
        input  req_wready, out_write, out_data, out_src, busy
    );

    // The arbiter itself
    modport slave (
        input  req_write, req_data, en_mask, out_wready,
        output req_wready, out_write, out_data, out_src, busy
    );
endinterface

// File: rtl/port_arbiter.sv
// rtl/port_arbiter.sv - round-robin N-to-1 word arbiter with a single-word output register
module port_arbiter #(
    parameter int N  = 4,
    parameter int W  = 11,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    port_arbiter_if.slave  bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state;
    logic [W-1:0]  out_data_r;
    logic [SW-1:0] out_src_r;
    logic [SW-1:0] last;

    logic [N-1:0]  elig;
    logic          can_take;
    logic          gnt_any;
    logic [SW-1:0] gnt_idx;
    logic          grant;

    assign elig     = bus.req_write & bus.en_mask;
    assign can_take = (state == EMPTY) || bus.out_wready;
    // Reset gating keeps sources from handing over a word that the reset edge would discard.
    assign grant    = rst_n && can_take && gnt_any;

    // Pick the first eligible requester after the last winner, wrapping at N
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = int'(last) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!gnt_any && elig[j]) begin
                gnt_any = 1'b1;
                gnt_idx = SW'(j);
            end
        end
    end

    // One-hot accept toward the winning requester
    always_comb begin
        bus.req_wready = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_wready[i] = grant && (gnt_idx == SW'(i));
        end
    end

    // Output register and fill state; a grant refills in the same cycle the old word leaves
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_data_r <= '0;
            out_src_r  <= '0;
            last       <= SW'(N - 1);
        end else if (grant) begin
            state      <= FULL;
            out_data_r <= bus.req_data[gnt_idx];
            out_src_r  <= gnt_idx;
            last       <= gnt_idx;
        end else if (state == FULL && bus.out_wready) begin
            state      <= EMPTY;
        end
    end

    assign bus.out_write = (state == FULL);
    assign bus.out_data  = out_data_r;
    assign bus.out_src   = out_src_r;
    assign bus.busy      = (state == FULL) || (|elig);
endmodule

// File: tb/tb_port_arbiter.sv
// tb/tb_port_arbiter.sv - directed vector bench for port_arbiter
module tb_port_arbiter;
    localparam int N = 4;
    localparam int W = 11;

    typedef struct {
        logic [3:0]        rw;
        logic [3:0]        em;
        logic              owr;
        logic [3:0][10:0]  d;
        logic [3:0]        ewr;
        logic              eow;
        logic [10:0]       eod;
        logic [1:0]        eos;
        logic              ebusy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    port_arbiter_if #(.N(N), .W(W)) bus();

    port_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", tag, field, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rw, input logic [3:0] em, input logic owr, input logic [3:0][10:0] d);
        bus.req_write  = rw;
        bus.en_mask    = em;
        bus.out_wready = owr;
        bus.req_data   = d;
    endtask

    // Sample 2 time units after the drive point, well clear of the clock edge
    task automatic expect_out(input string tag, input logic [3:0] ewr, input logic eow,
                              input logic [10:0] eod, input logic [1:0] eos, input logic ebusy);
        #2;
        check(tag, "req_wready", 32'(bus.req_wready), 32'(ewr));
        check(tag, "out_write",  32'(bus.out_write),  32'(eow));
        check(tag, "out_data",   32'(bus.out_data),   32'(eod));
        check(tag, "out_src",    32'(bus.out_src),    32'(eos));
        check(tag, "busy",       32'(bus.busy),       32'(ebusy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] rw, input logic [3:0] em, input logic owr,
                       input logic [10:0] d0, input logic [10:0] d1, input logic [10:0] d2, input logic [10:0] d3,
                       input logic [3:0] ewr, input logic eow, input logic [10:0] eod, input logic [1:0] eos,
                       input logic ebusy);
        vec_t v;
        v.rw = rw; v.em = em; v.owr = owr;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.ewr = ewr; v.eow = eow; v.eod = eod; v.eos = eos; v.ebusy = ebusy;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0][10:0] dd;

        // Consecutive cycles starting right after reset (EMPTY, last=3)
        // single requester 2, new word every cycle
        add(4'b0100, 4'hF, 1, 0, 0, 11'h7FF, 0,   4'b0100, 0, 11'd0,   2'd0, 1);
        add(4'b0100, 4'hF, 1, 0, 0, 11'd5,  0,    4'b0100, 1, 11'h7FF, 2'd2, 1);
        add(4'b0100, 4'hF, 1, 0, 0, 11'd6,  0,    4'b0100, 1, 11'd5,   2'd2, 1);
        // all four requesting, round robin continues from last=2 (wraps 3 -> 0)
        add(4'hF, 4'hF, 1, 10, 20, 30, 40,        4'b1000, 1, 11'd6,   2'd2, 1);
        add(4'hF, 4'hF, 1, 10, 20, 30, 40,        4'b0001, 1, 11'd40,  2'd3, 1);
        add(4'hF, 4'hF, 1, 10, 20, 30, 40,        4'b0010, 1, 11'd10,  2'd0, 1);
        add(4'hF, 4'hF, 1, 10, 20, 30, 40,        4'b0100, 1, 11'd20,  2'd1, 1);
        add(4'hF, 4'hF, 1, 10, 20, 30, 40,        4'b1000, 1, 11'd30,  2'd2, 1);
        add(4'hF, 4'hF, 1, 10, 20, 30, 40,        4'b0001, 1, 11'd40,  2'd3, 1);
        // en_mask 1010: sources 1 and 3 alternate
        add(4'hF, 4'b1010, 1, 10, 20, 30, 40,     4'b0010, 1, 11'd10,  2'd0, 1);
        add(4'hF, 4'b1010, 1, 10, 20, 30, 40,     4'b1000, 1, 11'd20,  2'd1, 1);
        add(4'hF, 4'b1010, 1, 10, 20, 30, 40,     4'b0010, 1, 11'd40,  2'd3, 1);
        add(4'hF, 4'b1010, 1, 10, 20, 30, 40,     4'b1000, 1, 11'd20,  2'd1, 1);
        // clear bit 3: held word from source 3 still delivered, then source 1 only
        add(4'hF, 4'b0010, 1, 10, 20, 30, 40,     4'b0010, 1, 11'd40,  2'd3, 1);
        add(4'hF, 4'b0010, 1, 10, 20, 30, 40,     4'b0010, 1, 11'd20,  2'd1, 1);
        add(4'hF, 4'b0010, 1, 10, 20, 30, 40,     4'b0010, 1, 11'd20,  2'd1, 1);
        // nothing eligible while FULL & out_wready: goes EMPTY, data/src kept
        add(4'hF, 4'b0000, 1, 10, 20, 30, 40,     4'b0000, 1, 11'd20,  2'd1, 1);
        add(4'hF, 4'b0000, 1, 10, 20, 30, 40,     4'b0000, 0, 11'd20,  2'd1, 0);

        // Reset with requests present: no accept during reset
        rst_n = 1'b0;
        dd = '0;
        drive(4'hF, 4'hF, 1, dd);
        step();
        expect_out("reset", 4'b0000, 0, 11'd0, 2'd0, 1);
        step();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rw, vecs[i].em, vecs[i].owr, vecs[i].d);
            expect_out($sformatf("vec%0d", i), vecs[i].ewr, vecs[i].eow, vecs[i].eod, vecs[i].eos, vecs[i].ebusy);
            step();
        end

        // Backpressure: capture 999 from source 0, hold 5 cycles, then release
        dd[0] = 11'd999; dd[1] = 11'd111; dd[2] = 11'd222; dd[3] = 11'd333;
        drive(4'b0001, 4'hF, 0, dd);
        expect_out("bp_load", 4'b0001, 0, 11'd20, 2'd1, 1);
        step();
        for (int c = 0; c < 5; c++) begin
            drive(4'hF, 4'hF, 0, dd);
            expect_out($sformatf("bp_hold%0d", c), 4'b0000, 1, 11'd999, 2'd0, 1);
            step();
        end
        drive(4'hF, 4'hF, 1, dd);
        expect_out("bp_release", 4'b0010, 1, 11'd999, 2'd0, 1);
        step();
        drive(4'b0000, 4'hF, 0, dd);
        expect_out("bp_next", 4'b0000, 1, 11'd111, 2'd1, 1);
        step();

        // Drain: one word from source 0, then nothing
        dd[0] = 11'd77;
        drive(4'b0001, 4'hF, 1, dd);
        expect_out("drain_grant", 4'b0001, 1, 11'd111, 2'd1, 1);
        step();
        drive(4'b0000, 4'hF, 1, dd);
        expect_out("drain_full", 4'b0000, 1, 11'd77, 2'd0, 1);
        step();
        expect_out("drain_empty", 4'b0000, 0, 11'd77, 2'd0, 0);
        step();
        expect_out("drain_idle", 4'b0000, 0, 11'd77, 2'd0, 0);
        step();

        // Reset while FULL with everyone requesting (last=0 here)
        dd[0] = 11'd5; dd[1] = 11'd6; dd[2] = 11'd7; dd[3] = 11'd8;
        drive(4'hF, 4'hF, 1, dd);
        expect_out("rst_fill", 4'b0010, 0, 11'd77, 2'd0, 1);
        step();
        rst_n = 1'b0;
        expect_out("rst_cycle", 4'b0000, 1, 11'd6, 2'd1, 1);
        step();
        rst_n = 1'b1;
        expect_out("rst_after", 4'b0001, 0, 11'd0, 2'd0, 1);
        step();
        drive(4'b0000, 4'hF, 0, dd);
        expect_out("rst_first", 4'b0000, 1, 11'd5, 2'd0, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
